// File: rtl/output_port_arbiter_pkg.sv
// Shared constants and types for the per-output-port switch allocator.
// Direction indices, port count and arbiter state encoding live here.
package output_port_arbiter_pkg;

  localparam int unsigned DIRECTIONS = 5;
  localparam int unsigned BITS_DIR   = 3;
  localparam int unsigned PKT_W      = 16;

  localparam int unsigned NORTH = 0;
  localparam int unsigned EAST  = 1;
  localparam int unsigned SOUTH = 2;
  localparam int unsigned WEST  = 3;
  localparam int unsigned LOCAL = 4;

  typedef enum logic [0:0] {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant bundle between the input ports' datapath and one output arbiter.
// The master side drives requests and transfer strobes; the slave side is the arbiter.
interface output_port_arbiter_if #(
  parameter int unsigned DIRS  = output_port_arbiter_pkg::DIRECTIONS,
  parameter int unsigned IDX_W = output_port_arbiter_pkg::BITS_DIR
) ();

  logic [DIRS-1:0]  req;
  logic [DIRS-1:0]  tail;
  logic             flit_xfer;
  logic             out_busy;
  logic [DIRS-1:0]  grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             stall_err;
  logic [15:0]      pkt_count;

  modport master (
    output req, tail, flit_xfer, out_busy,
    input  grant, grant_valid, grant_idx, stall_err, pkt_count
  );

  modport slave (
    input  req, tail, flit_xfer, out_busy,
    output grant, grant_valid, grant_idx, stall_err, pkt_count
  );

endinterface

// File: rtl/output_port_arbiter_rr_pick.sv
// Cyclic priority scan: first set req bit at or after rr_ptr, wrapping at DIRS.
// Purely combinational; also used by the VC allocator.
module output_port_arbiter_rr_pick #(
  parameter int unsigned DIRS  = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [DIRS-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < int'(DIRS); k++) begin
      // rr_ptr < DIRS, so one conditional subtract is enough to wrap
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(DIRS)) begin
        sum = sum - (IDX_W + 1)'(DIRS);
      end
      pos = sum[IDX_W-1:0];
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port allocator: round-robin grant locked for a whole packet, with a
// stall watchdog that frees the output when the owner stops sending flits.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int unsigned DIRS        = DIRECTIONS,
  parameter int unsigned IDX_W       = BITS_DIR,
  parameter int unsigned STALL_LIMIT = 255,
  parameter int unsigned STALL_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output_port_arbiter_if.slave  bus
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_err_q, stall_err_d;
  logic [PKT_W-1:0] pkt_count_q, pkt_count_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] owner_next;

  output_port_arbiter_rr_pick #(
    .DIRS  (DIRS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // DIRS is not a power of two, so wrap by compare rather than by masking
  assign owner_next = (owner_q == IDX_W'(DIRS - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = 1'b0;
    pkt_count_d = pkt_count_q;
    unique case (state_q)
      ArbIdle: begin
        if (pick_found) begin
          state_d     = ArbLocked;
          owner_d     = pick_idx;
          stall_cnt_d = '0;
        end
      end
      ArbLocked: begin
        if (bus.flit_xfer && bus.tail[owner_q]) begin
          state_d     = ArbIdle;
          rr_ptr_d    = owner_next;
          stall_cnt_d = '0;
          pkt_count_d = pkt_count_q + 1'b1;
        end else if (bus.flit_xfer) begin
          stall_cnt_d = '0;
        end else if (!bus.out_busy) begin
          // Backpressured cycles do not count towards the watchdog
          if ((STALL_LIMIT != 0) && (stall_cnt_q == STALL_W'(STALL_LIMIT - 1))) begin
            state_d     = ArbIdle;
            rr_ptr_d    = owner_next;
            stall_cnt_d = '0;
            stall_err_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ArbIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    bus.grant = '0;
    for (int i = 0; i < int'(DIRS); i++) begin
      bus.grant[i] = (state_q == ArbLocked) && (owner_q == IDX_W'(i));
    end
  end

  assign bus.grant_valid = (state_q == ArbLocked);
  assign bus.grant_idx   = owner_q;
  assign bus.stall_err   = stall_err_q;
  assign bus.pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench: two arbiters (watchdog limits 255 and 4) share one stimulus stream
// and are each compared cycle by cycle against a packet-level reference model.
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;

  localparam int N = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  output_port_arbiter_if ifc0 ();
  output_port_arbiter_if ifc1 ();

  output_port_arbiter #(.STALL_LIMIT(255)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc0)
  );

  output_port_arbiter #(.STALL_LIMIT(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc1)
  );

  typedef struct packed {
    logic [4:0]  grant;
    logic        gv;
    logic [2:0]  idx;
    logic        err;
    logic [15:0] pkt;
  } exp_t;

  typedef struct packed {
    exp_t e0;
    exp_t e1;
  } exp_pair_t;

  exp_pair_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: owner = -1 means the output is free
  int m_owner[2];
  int m_ptr[2];
  int m_stall[2];
  int m_idx[2];
  int m_pkt[2];
  int m_lim[2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_stall[d] = 0;
      m_idx[d]   = 0;
      m_pkt[d]   = 0;
    end
    m_lim[0] = 255;
    m_lim[1] = 4;
  endfunction

  function automatic exp_t model_step(int d, logic [4:0] r, logic [4:0] t, logic x, logic b);
    exp_t e;
    logic err = 1'b0;
    logic done = 1'b0;
    if (m_owner[d] < 0) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr[d] + k) % N;
        if (!done && r[i]) begin
          m_owner[d] = i;
          m_idx[d]   = i;
          m_stall[d] = 0;
          done       = 1'b1;
        end
      end
    end else if (x && t[m_owner[d]]) begin
      m_pkt[d]   = (m_pkt[d] + 1) % 65536;
      m_ptr[d]   = (m_owner[d] + 1) % N;
      m_owner[d] = -1;
    end else if (x) begin
      m_stall[d] = 0;
    end else if (!b) begin
      m_stall[d] = m_stall[d] + 1;
      if (m_lim[d] != 0 && m_stall[d] >= m_lim[d]) begin
        m_ptr[d]   = (m_owner[d] + 1) % N;
        m_owner[d] = -1;
        m_stall[d] = 0;
        err        = 1'b1;
      end
    end
    e.grant = (m_owner[d] >= 0) ? 5'(1 << m_owner[d]) : 5'd0;
    e.gv    = (m_owner[d] >= 0);
    e.idx   = 3'(m_idx[d]);
    e.err   = err;
    e.pkt   = 16'(m_pkt[d]);
    return e;
  endfunction

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, d, $time, act, exp);
    end
  endtask

  task automatic cmp(input int d, input exp_t e, input logic [4:0] g, input logic gv,
                     input logic [2:0] idx, input logic err, input logic [15:0] pkt);
    chk("grant", d, 16'(g), 16'(e.grant));
    chk("grant_valid", d, 16'(gv), 16'(e.gv));
    chk("grant_idx", d, 16'(idx), 16'(e.idx));
    chk("stall_err", d, 16'(err), 16'(e.err));
    chk("pkt_count", d, pkt, e.pkt);
  endtask

  // Monitor: each expectation describes the DUT right after the next rising edge
  initial begin
    exp_pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        p = sb.pop_front();
        cmp(0, p.e0, ifc0.grant, ifc0.grant_valid, ifc0.grant_idx, ifc0.stall_err,
            ifc0.pkt_count);
        cmp(1, p.e1, ifc1.grant, ifc1.grant_valid, ifc1.grant_idx, ifc1.stall_err,
            ifc1.pkt_count);
      end
    end
  end

  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic x, input logic b);
    ifc0.req = r; ifc0.tail = t; ifc0.flit_xfer = x; ifc0.out_busy = b;
    ifc1.req = r; ifc1.tail = t; ifc1.flit_xfer = x; ifc1.out_busy = b;
  endtask

  task automatic cycle(input logic [4:0] r, input logic [4:0] t, input logic x, input logic b);
    exp_pair_t p;
    @(negedge clk);
    drive(r, t, x, b);
    p.e0 = model_step(0, r, t, x, b);
    p.e1 = model_step(1, r, t, x, b);
    sb.push_back(p);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_grant"}, 0, 16'(ifc0.grant), 16'd0);
    chk({nm, "_grant"}, 1, 16'(ifc1.grant), 16'd0);
    chk({nm, "_idx"}, 0, 16'(ifc0.grant_idx), 16'd0);
    chk({nm, "_idx"}, 1, 16'(ifc1.grant_idx), 16'd0);
    chk({nm, "_gv"}, 0, 16'(ifc0.grant_valid), 16'd0);
    chk({nm, "_pkt"}, 1, ifc1.pkt_count, 16'd0);
  endtask

  // Asserted between edges; outputs must clear before any clock edge
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [4:0] r, t;
    drive('0, '0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single-flit packet on input 2
    cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
    cycle(5'b00100, 5'b00100, 1'b1, 1'b0);
    cycle(5'b00000, 5'b00000, 1'b0, 1'b0);

    // All inputs requesting, 3-flit packets back to back
    for (int p = 0; p < 6; p++) begin
      cycle(5'b11111, 5'b00000, 1'b0, 1'b0);
      cycle(5'b11111, 5'b00000, 1'b1, 1'b0);
      cycle(5'b11111, 5'b00000, 1'b1, 1'b0);
      cycle(5'b11111, 5'b11111, 1'b1, 1'b0);
    end

    // Owner 1 goes quiet while input 3 waits
    cycle(5'b00010, 5'b00000, 1'b0, 1'b0);
    repeat (10) cycle(5'b01000, 5'b00000, 1'b0, 1'b0);
    cycle(5'b01010, 5'b00010, 1'b1, 1'b0);
    cycle(5'b01000, 5'b00000, 1'b0, 1'b0);

    // Backpressure never trips the watchdog, then idle time does
    repeat (100) cycle(5'b10000, 5'b00000, 1'b0, 1'b1);
    repeat (6) cycle(5'b10000, 5'b00000, 1'b0, 1'b0);

    // Async reset mid-packet, then re-grant from rr_ptr=0
    async_reset();
    cycle(5'b01000, 5'b00000, 1'b0, 1'b0);
    cycle(5'b01000, 5'b00000, 1'b1, 1'b0);
    async_reset();
    cycle(5'b01000, 5'b00000, 1'b0, 1'b0);
    cycle(5'b01000, 5'b01000, 1'b1, 1'b0);

    // Counter wrap: preload just below 65535, then finish three one-flit packets
    async_reset();
    @(negedge clk);
    force dut0.pkt_count_q = 16'hfffd;
    force dut1.pkt_count_q = 16'hfffd;
    #1;
    release dut0.pkt_count_q;
    release dut1.pkt_count_q;
    m_pkt[0] = 65533;
    m_pkt[1] = 65533;
    repeat (3) begin
      cycle(5'b00010, 5'b00010, 1'b1, 1'b0);
      cycle(5'b00010, 5'b00010, 1'b1, 1'b0);
    end
    cycle(5'b00000, 5'b00000, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      r = 5'($urandom_range(0, 31));
      for (int i = 0; i < N; i++) begin
        t[i] = ($urandom_range(0, 2) == 0);
      end
      cycle(r, t, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    cycle(5'b00000, 5'b00000, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("sb_drained", 0, 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port allocator for the router's switch.
- Shares one output transmitter (tx_logic/tx) between the DIRECTIONS input ports: NORTH, EAST, SOUTH, WEST and LOCAL.
- Grants are round-robin and locked for a whole packet, from head flit until the tail flit is transferred.
- A stall watchdog releases a lock whose owner stops supplying flits while the downstream link is not busy.
- One instance per output port inside router.

Parameters:
- DIRS, default `DIRECTIONS (5): number of requesting input ports.
- IDX_W, default `BITS_DIR (3): width of the port index.
- STALL_LIMIT, default 255: number of non-backpressured idle cycles in LOCKED before a forced release. A value of 0 disables the watchdog.
- STALL_W, default 8: width of the stall counter. Must satisfy STALL_LIMIT < 2^STALL_W.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req, input, DIRS: bit i=1 when input i's FIFO head flit is routed to this output.
- tail, input, DIRS: bit i=1 when input i's FIFO head flit is a tail flit.
- flit_xfer, input, 1: the datapath moved one flit from the granted input into the transmitter this cycle.
- out_busy, input, 1: downstream tx_busy (backpressure).
- grant, output, DIRS: one-hot grant, all zeros when none.
- grant_valid, output, 1: equals |grant.
- grant_idx, output, IDX_W: binary index of the granted input. Holds its last value when grant_valid=0.
- stall_err, output, 1: one-cycle pulse on a watchdog release.
- pkt_count, output, 16: count of packets completed by tail flit. Wraps at 65535 -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=0, grant_valid=0, grant_idx=0.
  - rr_ptr=0, stall_cnt=0, stall_err=0, pkt_count=0.
  - Asserting reset mid-packet drops the lock immediately. No tail accounting is done for that packet.
- State IDLE:
  - If req!=0: pick the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo DIRS (wrap 4 -> 0).
  - Next edge: grant=onehot(i), grant_idx=i, state=LOCKED, stall_cnt=0.
  - Latency is 1 cycle from req to grant.
  - If req=0: remain in IDLE.
  - flit_xfer is ignored in IDLE.
- State LOCKED (owner g):
  - Grant is held regardless of req[g]. Deassertion of req[g] is treated as a temporarily empty FIFO, not packet end.
  - req and tail bits of non-owners are ignored.
  - flit_xfer=1 and tail[g]=1: next edge grant=0, state=IDLE, rr_ptr=(g+1) mod DIRS, pkt_count+=1. Re-arbitration happens in the following IDLE cycle, giving exactly one bubble cycle between packets.
  - flit_xfer=1 and tail[g]=0: stall_cnt=0, remain LOCKED.
  - flit_xfer=0 and out_busy=1: stall_cnt holds. Backpressure is legitimate.
  - flit_xfer=0 and out_busy=0: stall_cnt+=1.
  - When stall_cnt would reach STALL_LIMIT (STALL_LIMIT!=0): next edge grant=0, state=IDLE, rr_ptr=(g+1) mod DIRS, stall_err=1 for one cycle, pkt_count unchanged.
- Simultaneous events: flit_xfer with tail on the same cycle the stall limit is reached is a normal release. stall_err stays 0 and pkt_count increments.
- Invariants:
  - grant is never multi-hot.
  - grant_valid=1 exactly in LOCKED.
  - Each grant edge changes at most one bit from 0.
- Arithmetic: rr_ptr increment uses compare-and-wrap (not a power-of-2 mask), since DIRS=5. The counters are unsigned.

Decomposition:
- DIRECTIONS, BITS_DIR and the direction indices (NORTH/EAST/SOUTH/WEST/LOCAL) stay in constants.v.
- The state encodings ARB_IDLE=0 and ARB_LOCKED=1 are added there as well.
- One combinational sub-module, rr_pick (inputs: req, rr_ptr; outputs: found, idx), does the cyclic priority scan. It is reused later by the VC allocator.
- The FSM, the stall counter and pkt_count live in output_port_arbiter.

Test Plan:
- Reset then req=5'b00100 held, single-flit packet (tail=1, flit_xfer=1 one cycle after grant):
  - grant=00100 and grant_idx=2 one cycle after req.
  - Released the cycle after xfer; rr_ptr=3, pkt_count=1.
- req=5'b11111 continuously, each packet 3 flits with xfer every cycle:
  - Grant order is 0,1,2,3,4,0.
  - One bubble cycle between grants; pkt_count=6 after six packets.
- Owner 1 drops req for 10 cycles mid-packet while req[3]=1, STALL_LIMIT=255:
  - grant stays 00010; input 3 is not granted until input 1's tail transfers.
- STALL_LIMIT=4, owner idle, out_busy=0:
  - Release after the 4th idle cycle; stall_err pulses once; pkt_count unchanged.
  - With out_busy=1 for 100 idle cycles there is no release.
- Reset asserted asynchronously mid-packet (grant=01000):
  - grant=0 and grant_idx=0 immediately, before any clock edge.
  - After reset release with req=01000, input 3 is granted again from rr_ptr=0.
- pkt_count preloaded near wrap via 65536 one-flit packets: pkt_count reads 0 and no X appears.
